insn_prefetch: RTL and testbench

INSN_PREFETCH -- requirements
Module: insn_prefetch

---
 rtl/insn_prefetch_pkg.sv | 24 ++
 rtl/vcpu_pkg.sv | 12 +
 rtl/insn_prefetch_fifo.sv | 67 ++++++
 rtl/insn_prefetch.sv | 135 +++++++++++++
 tb/tb_insn_prefetch.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/insn_prefetch_pkg.sv
// Types and helpers for the instruction prefetcher and its queue.
package insn_prefetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        RELEASE = 2'b10,
        DISCARD = 2'b11
    } pf_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] data;
    } pf_entry_t;

    function automatic logic [31:0] pc_step(input logic [31:0] pc);
        return pc + 32'd2;
    endfunction

    function automatic logic [31:0] align_pc(input logic [31:0] a);
        return {a[31:1], 1'b0};
    endfunction

endpackage

// File: rtl/vcpu_pkg.sv
// Shared vcpu bus definitions: cache bus request codes and transfer size encodings.
package vcpu_pkg;

    localparam logic [2:0] BR_IDLE  = 3'b000;
    localparam logic [2:0] BR_READ  = 3'b001;
    localparam logic [2:0] BR_WRITE = 3'b010;

    localparam logic [1:0] SIZ_WORD = 2'b00;
    localparam logic [1:0] SIZ_BYTE = 2'b01;
    localparam logic [1:0] SIZ_HALF = 2'b10;

endpackage

// File: rtl/insn_prefetch_fifo.sv
// Prefetch queue: DEPTH x 48-bit FIFO of {addr, data} with flush and occupancy level.
module prefetch_fifo
    import insn_prefetch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       flush,
    input  logic       push,
    input  pf_entry_t  push_entry,
    input  logic       pop,
    output pf_entry_t  head,
    output logic       valid,
    output logic [4:0] level
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [4:0]       DEPTH_L = 5'(DEPTH);

    pf_entry_t        mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [4:0]       level_r;
    logic             valid_r;
    logic             push_s;
    logic             pop_s;
    logic [4:0]       level_nxt_s;

    // Qualify push/pop against full/empty and compute the next occupancy.
    always_comb begin
        push_s      = push && (level_r != DEPTH_L);
        pop_s       = pop && (level_r != 5'd0);
        level_nxt_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + 5'd1;
            2'b01:   level_nxt_s = level_r - 5'd1;
            default: level_nxt_s = level_r;
        endcase
    end

    // Pointer, level and valid registers; flush has priority over push and pop.
    always_ff @(posedge CLK) begin
        if (nRESET || flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= 5'd0;
            valid_r  <= 1'b0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            level_r <= level_nxt_s;
            valid_r <= (level_nxt_s != 5'd0);
        end
    end

    // Entry storage; contents need no reset since valid gates their use.
    always_ff @(posedge CLK) begin
        if (push_s && !flush && !nRESET) mem_r[wr_ptr_r] <= push_entry;
    end

    assign head  = mem_r[rd_ptr_r];
    assign valid = valid_r;
    assign level = level_r;

endmodule

// File: rtl/insn_prefetch.sv
// Instruction prefetcher: fetches sequential halfwords from the instruction cache
// into a small queue feeding the decoder, with flush/redirect support.
module insn_prefetch
    import vcpu_pkg::*;
    import insn_prefetch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic [2:0]  cache_br,
    output logic [31:0] cache_a,
    input  logic [15:0] cache_data,
    input  logic        cache_compl,
    output logic [15:0] q_data,
    output logic [31:0] q_addr,
    output logic        q_valid,
    input  logic        q_ready,
    output logic [4:0]  q_level
);

    localparam logic [4:0] DEPTH_L = 5'(DEPTH);

    pf_state_t   state_r;
    pf_state_t   state_nxt_s;
    logic [31:0] pc_r;
    logic [31:0] pc_nxt_s;
    logic [2:0]  br_r;
    logic [2:0]  br_nxt_s;
    logic [31:0] a_r;
    logic [31:0] a_nxt_s;
    logic        push_s;
    logic        pop_s;
    logic        has_room_s;
    pf_entry_t   push_entry_s;
    pf_entry_t   head_s;

    // Next-state, next-pc and cache request decode.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        br_nxt_s    = br_r;
        a_nxt_s     = a_r;
        push_s      = 1'b0;
        has_room_s  = (q_level != DEPTH_L);
        case (state_r)
            IDLE: begin
                // Holding off while cache_compl is high also covers the tag-RAM clear after reset.
                if (flush) begin
                    pc_nxt_s = align_pc(flush_pc);
                end else if (has_room_s && !cache_compl) begin
                    br_nxt_s    = BR_READ;
                    a_nxt_s     = pc_r;
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                if (flush) begin
                    pc_nxt_s    = align_pc(flush_pc);
                    state_nxt_s = DISCARD;
                end else if (cache_compl) begin
                    push_s      = 1'b1;
                    pc_nxt_s    = pc_step(pc_r);
                    br_nxt_s    = BR_IDLE;
                    state_nxt_s = RELEASE;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            RELEASE: begin
                pc_nxt_s    = flush ? align_pc(flush_pc) : pc_r;
                state_nxt_s = cache_compl ? RELEASE : IDLE;
            end
            DISCARD: begin
                pc_nxt_s = flush ? align_pc(flush_pc) : pc_r;
                if (cache_compl) begin
                    br_nxt_s    = BR_IDLE;
                    state_nxt_s = RELEASE;
                end else begin
                    state_nxt_s = DISCARD;
                end
            end
            default: begin
                br_nxt_s    = BR_IDLE;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (nRESET) state_r <= IDLE;
        else        state_r <= state_nxt_s;
    end

    // Fetch pointer and registered cache request outputs.
    always_ff @(posedge CLK) begin
        if (nRESET) begin
            pc_r <= 32'h0000_0000;
            br_r <= BR_IDLE;
            a_r  <= 32'h0000_0000;
        end else begin
            pc_r <= pc_nxt_s;
            br_r <= br_nxt_s;
            a_r  <= a_nxt_s;
        end
    end

    assign push_entry_s = '{addr: cache_a, data: cache_data};
    assign pop_s        = q_valid && q_ready;

    prefetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .nRESET    (nRESET),
        .flush     (flush),
        .push      (push_s),
        .push_entry(push_entry_s),
        .pop       (pop_s),
        .head      (head_s),
        .valid     (q_valid),
        .level     (q_level)
    );

    assign cache_br = br_r;
    assign cache_a  = a_r;
    assign q_data   = head_s.data;
    assign q_addr   = head_s.addr;

endmodule

// File: tb/tb_insn_prefetch.sv
// Directed bench for insn_prefetch: auto-responding cache for streaming tests,
// manual cache handshake for flush/discard, wrap and reset corner cases.
module tb_insn_prefetch;
    import vcpu_pkg::*;

    logic        CLK;
    logic        nRESET;
    logic        flush;
    logic [31:0] flush_pc;
    logic [2:0]  cache_br;
    logic [31:0] cache_a;
    logic [15:0] cache_data;
    logic        cache_compl;
    logic [15:0] q_data;
    logic [31:0] q_addr;
    logic        q_valid;
    logic        q_ready;
    logic [4:0]  q_level;

    logic        resp_en;
    logic        data_mode;
    logic [31:0] win_lo;
    logic        auto_compl;
    logic [15:0] auto_data;
    logic        man_compl;
    logic [15:0] man_data;
    int          resp_cnt;
    int          req_cnt;
    int          wait_cnt;
    int          total;
    int          bad;
    int          req_base;
    logic [31:0] ea;

    assign cache_compl = resp_en ? auto_compl : man_compl;
    assign cache_data  = resp_en ? auto_data  : man_data;

    insn_prefetch #(.DEPTH(8)) dut (
        .CLK        (CLK),
        .nRESET     (nRESET),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .cache_br   (cache_br),
        .cache_a    (cache_a),
        .cache_data (cache_data),
        .cache_compl(cache_compl),
        .q_data     (q_data),
        .q_addr     (q_addr),
        .q_valid    (q_valid),
        .q_ready    (q_ready),
        .q_level    (q_level)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Cache model: completes a read two cycles after it appears, drops compl once withdrawn.
    initial begin
        auto_compl = 1'b0;
        auto_data  = 16'h0000;
        resp_cnt   = 0;
        req_cnt    = 0;
        wait_cnt   = 0;
        forever begin
            @(negedge CLK);
            if (resp_en) begin
                if (auto_compl) begin
                    if (cache_br !== BR_READ) auto_compl = 1'b0;
                end else if (cache_br === BR_READ) begin
                    if (wait_cnt >= 1) begin
                        auto_compl = 1'b1;
                        auto_data  = data_mode ? ~cache_a[15:0] : 16'(16'hA000 + resp_cnt);
                        resp_cnt   = resp_cnt + 1;
                        if (cache_a >= win_lo) req_cnt = req_cnt + 1;
                        wait_cnt   = 0;
                    end else begin
                        wait_cnt = wait_cnt + 1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_br_read(input string tag);
        int n;
        n = 0;
        while (cache_br !== BR_READ && n < 60) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, cache_br === BR_READ}, 32'd1);
    endtask

    task automatic wait_q_valid(input string tag);
        int n;
        n = 0;
        while (q_valid !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, q_valid}, 32'd1);
    endtask

    task automatic manual_xact(input string tag, input logic [31:0] exp_a, input logic [15:0] d);
        wait_br_read(tag);
        chk(tag, cache_a, exp_a);
        man_data  = d;
        man_compl = 1'b1;
        tick();
        man_compl = 1'b0;
        tick();
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        resp_en   = 1'b0;
        data_mode = 1'b0;
        win_lo    = 32'hFFFF_FFFF;
        man_compl = 1'b0;
        man_data  = 16'h0000;
        nRESET    = 1'b1;
        flush     = 1'b0;
        flush_pc  = 32'h0;
        q_ready   = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_br", {29'd0, cache_br}, {29'd0, BR_IDLE});
        chk("rst_a", cache_a, 32'h0);
        chk("rst_valid", {31'd0, q_valid}, 32'd0);
        chk("rst_level", {27'd0, q_level}, 32'd0);

        // Streaming from 0x1000 with counting data; pop on empty ignored
        nRESET   = 1'b0;
        flush    = 1'b1;
        flush_pc = 32'h0000_1000;
        q_ready  = 1'b1;
        resp_en  = 1'b1;
        tick();
        flush = 1'b0;
        chk("pop_empty_level", {27'd0, q_level}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            wait_q_valid("stream_valid");
            chk("stream_addr", q_addr, 32'h1000 + 32'(2 * k));
            chk("stream_data", {16'd0, q_data}, {16'd0, 16'(16'hA000 + k)});
            tick();
        end

        // Fill to DEPTH with decoder stalled, then drain and resume
        data_mode = 1'b1;
        win_lo    = 32'h0000_3000;
        q_ready   = 1'b0;
        flush     = 1'b1;
        flush_pc  = 32'h0000_3000;
        req_base  = req_cnt;
        tick();
        flush = 1'b0;
        repeat (60) tick();
        chk("full_level", {27'd0, q_level}, 32'd8);
        chk("full_reqs", 32'(req_cnt - req_base), 32'd8);
        chk("full_br_idle", {29'd0, cache_br}, {29'd0, BR_IDLE});
        repeat (5) tick();
        chk("full_br_still_idle", {29'd0, cache_br}, {29'd0, BR_IDLE});
        q_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wait_q_valid("drain_valid");
            ea = 32'h3000 + 32'(2 * k);
            chk("drain_addr", q_addr, ea);
            chk("drain_data", {16'd0, q_data}, {16'd0, ~ea[15:0]});
            tick();
        end

        // Manual handshake: settle with compl held high, then redirect to 0x4000
        q_ready   = 1'b0;
        man_compl = 1'b1;
        resp_en   = 1'b0;
        repeat (3) tick();
        flush    = 1'b1;
        flush_pc = 32'h0000_4000;
        tick();
        flush = 1'b0;
        repeat (2) tick();
        man_compl = 1'b0;
        for (int i = 0; i < 4; i++) begin
            manual_xact("fill4_addr", 32'h4000 + 32'(2 * i), 16'(16'hC000 + i));
        end
        chk("level4", {27'd0, q_level}, 32'd4);

        // Simultaneous push and pop keeps the level
        wait_br_read("pp_req");
        chk("pp_req_addr", cache_a, 32'h4008);
        q_ready   = 1'b1;
        man_data  = 16'hC004;
        man_compl = 1'b1;
        tick();
        q_ready = 1'b0;
        chk("pp_level", {27'd0, q_level}, 32'd4);
        chk("pp_head", q_addr, 32'h4002);

        // Flush with same-cycle pop empties the queue
        q_ready  = 1'b1;
        flush    = 1'b1;
        flush_pc = 32'h0000_5000;
        tick();
        flush   = 1'b0;
        q_ready = 1'b0;
        chk("fpop_level", {27'd0, q_level}, 32'd0);
        chk("fpop_valid", {31'd0, q_valid}, 32'd0);
        man_compl = 1'b0;
        wait_br_read("redir_req");
        chk("redir_addr", cache_a, 32'h5000);

        // Flush during REQ, second flush during DISCARD, stale 0xDEAD dropped
        flush    = 1'b1;
        flush_pc = 32'h0000_6000;
        tick();
        flush_pc = 32'h0000_2001;
        tick();
        flush = 1'b0;
        tick();
        chk("disc_br_held", {29'd0, cache_br}, {29'd0, BR_READ});
        chk("disc_a_held", cache_a, 32'h5000);
        man_data  = 16'hDEAD;
        man_compl = 1'b1;
        tick();
        chk("disc_level", {27'd0, q_level}, 32'd0);
        chk("disc_valid", {31'd0, q_valid}, 32'd0);
        chk("disc_br_idle", {29'd0, cache_br}, {29'd0, BR_IDLE});
        man_compl = 1'b0;
        wait_br_read("after_disc_req");
        chk("after_disc_addr", cache_a, 32'h2000);
        man_data  = 16'h1234;
        man_compl = 1'b1;
        tick();
        chk("after_disc_valid", {31'd0, q_valid}, 32'd1);
        chk("after_disc_qaddr", q_addr, 32'h2000);
        chk("after_disc_qdata", {16'd0, q_data}, 32'h1234);
        chk("after_disc_level", {27'd0, q_level}, 32'd1);

        // Address wrap at top of memory
        flush    = 1'b1;
        flush_pc = 32'hFFFF_FFFE;
        tick();
        flush     = 1'b0;
        man_compl = 1'b0;
        wait_br_read("wrap_req");
        chk("wrap_a", cache_a, 32'hFFFF_FFFE);
        man_data  = 16'hBEEF;
        man_compl = 1'b1;
        tick();
        chk("wrap_qaddr", q_addr, 32'hFFFF_FFFE);
        chk("wrap_qdata", {16'd0, q_data}, 32'hBEEF);
        chk("wrap_level", {27'd0, q_level}, 32'd1);
        man_compl = 1'b0;
        wait_br_read("wrap_next_req");
        chk("wrap_next_a", cache_a, 32'h0000_0000);

        // Reset mid-REQ with cache_compl held high for 5 cycles
        nRESET    = 1'b1;
        man_compl = 1'b1;
        tick();
        nRESET = 1'b0;
        chk("mrst_br", {29'd0, cache_br}, {29'd0, BR_IDLE});
        chk("mrst_level", {27'd0, q_level}, 32'd0);
        chk("mrst_valid", {31'd0, q_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mrst_hold_idle", {29'd0, cache_br}, {29'd0, BR_IDLE});
        end
        man_compl = 1'b0;
        wait_br_read("mrst_req");
        chk("mrst_req_a", cache_a, 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
